// File: rtl/rsc_encoder.sv
// Frame-based 8-state RSC encoder (13/15 octal) with 3-step trellis termination
// and BPSK-mapped systematic/parity symbols.
module rsc_encoder #(
    parameter int                 FRAME_LEN = 64,
    parameter logic signed [15:0] AMP       = 16'sd1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic               sys_out,
    output logic               par_out,
    output logic signed [15:0] sys_sym,
    output logic signed [15:0] par_sym,
    output logic               out_valid,
    output logic [2:0]         trellis_state,
    output logic [7:0]         bit_cnt,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    localparam logic [7:0] LAST_BIT = 8'(FRAME_LEN - 1);

    state_t             state_q, state_d;
    logic               sys_q, sys_d;
    logic               par_q, par_d;
    logic signed [15:0] sys_sym_q, sys_sym_d;
    logic signed [15:0] par_sym_q, par_sym_d;
    logic               out_valid_q, out_valid_d;
    logic [2:0]         trellis_q, trellis_d;
    logic [7:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]         tail_cnt_q, tail_cnt_d;
    logic               done_q, done_d;

    logic step, u, f, p;

    always_comb begin
        state_d     = state_q;
        sys_d       = sys_q;
        par_d       = par_q;
        sys_sym_d   = sys_sym_q;
        par_sym_d   = par_sym_q;
        trellis_d   = trellis_q;
        bit_cnt_d   = bit_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        done_d      = 1'b0;
        step        = 1'b0;
        u           = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = DATA;
                    bit_cnt_d = 8'd0;
                    trellis_d = 3'b000;
                end
            end
            DATA: begin
                if (din_valid) begin
                    step      = 1'b1;
                    u         = din;
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = TAIL;
                        tail_cnt_d = 2'd0;
                    end
                end
            end
            TAIL: begin
                // u cancels the feedback taps, driving zeros into the register
                step       = 1'b1;
                u          = trellis_q[1] ^ trellis_q[0];
                tail_cnt_d = tail_cnt_q + 2'd1;
                if (tail_cnt_q == 2'd2) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        f = u ^ trellis_q[1] ^ trellis_q[0];
        p = f ^ trellis_q[2] ^ trellis_q[0];

        if (step) begin
            trellis_d = {f, trellis_q[2:1]};
            sys_d     = u;
            par_d     = p;
            sys_sym_d = u ? -AMP : AMP;
            par_sym_d = p ? -AMP : AMP;
        end else if (state_q == IDLE) begin
            sys_sym_d = 16'sd0;
            par_sym_d = 16'sd0;
        end
        out_valid_d = step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sys_q       <= 1'b0;
            par_q       <= 1'b0;
            sys_sym_q   <= 16'sd0;
            par_sym_q   <= 16'sd0;
            out_valid_q <= 1'b0;
            trellis_q   <= 3'b000;
            bit_cnt_q   <= 8'd0;
            tail_cnt_q  <= 2'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sys_q       <= sys_d;
            par_q       <= par_d;
            sys_sym_q   <= sys_sym_d;
            par_sym_q   <= par_sym_d;
            out_valid_q <= out_valid_d;
            trellis_q   <= trellis_d;
            bit_cnt_q   <= bit_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            done_q      <= done_d;
        end
    end

    assign din_ready     = (state_q == DATA);
    assign busy          = (state_q == DATA) || (state_q == TAIL);
    assign sys_out       = sys_q;
    assign par_out       = par_q;
    assign sys_sym       = sys_sym_q;
    assign par_sym       = par_sym_q;
    assign out_valid     = out_valid_q;
    assign trellis_state = trellis_q;
    assign bit_cnt       = bit_cnt_q;
    assign done          = done_q;

endmodule

// File: tb/tb_rsc_encoder.sv
// Directed + random bench for rsc_encoder: one FRAME_LEN=4 and one FRAME_LEN=64 instance.
module tb_rsc_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0, din_valid = 1'b0;
    logic start4 = 1'b0, start64 = 1'b0;

    logic               rdy4, sys4, par4, ov4, busy4, done4;
    logic signed [15:0] ssym4, psym4;
    logic [2:0]         st4;
    logic [7:0]         cnt4;
    logic               rdy64, sys64, par64, ov64, busy64, done64;
    logic signed [15:0] ssym64, psym64;
    logic [2:0]         st64;
    logic [7:0]         cnt64;

    always #5 clk = ~clk;

    rsc_encoder #(.FRAME_LEN(4), .AMP(16'sd1024)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .din(din), .din_valid(din_valid),
        .din_ready(rdy4), .sys_out(sys4), .par_out(par4), .sys_sym(ssym4), .par_sym(psym4),
        .out_valid(ov4), .trellis_state(st4), .bit_cnt(cnt4), .busy(busy4), .done(done4)
    );

    rsc_encoder #(.FRAME_LEN(64), .AMP(16'sd1024)) dut64 (
        .clk(clk), .rst(rst), .start(start64), .din(din), .din_valid(din_valid),
        .din_ready(rdy64), .sys_out(sys64), .par_out(par64), .sys_sym(ssym64), .par_sym(psym64),
        .out_valid(ov64), .trellis_state(st64), .bit_cnt(cnt64), .busy(busy64), .done(done64)
    );

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int done4_cnt = 0;

    // entry: {busy, done, sys, par, st[2:0], sys_sym, par_sym}
    logic [38:0] q4[$];
    int          q4_cyc[$];
    // entry: {done, sys, par, st[2:0], sys_sym}
    logic [21:0] q64[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ov4) begin
            q4.push_back({busy4, done4, sys4, par4, st4, ssym4, psym4});
            q4_cyc.push_back(cyc);
        end
        if (done4) done4_cnt++;
        if (ov64) q64.push_back({done64, sys64, par64, st64, ssym64});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference step of the 13/15 RSC code; s = {s1,s2,s3}.
    task automatic ref_step(input logic [2:0] s, input logic u, output logic p, output logic [2:0] ns);
        logic fb;
        fb = u ^ s[1] ^ s[0];
        p  = fb ^ s[2] ^ s[0];
        ns = {fb, s[2], s[1]};
    endtask

    task automatic pulse_start4();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
    endtask

    // Feed 4 bits (bits[0] first) to dut4; optional 2-cycle din_valid gap after gap_after bits,
    // with a start pulse during the gap that must be ignored.
    task automatic feed4(input logic [3:0] bits, input int gap_after);
        for (int i = 0; i < 4; i++) begin
            din = bits[i];
            din_valid = 1'b1;
            tick();
            if (i + 1 == gap_after) begin
                din_valid = 1'b0;
                start4 = 1'b1;
                tick();
                start4 = 1'b0;
                tick();
            end
        end
        din_valid = 1'b0;
        repeat (8) tick();
    endtask

    task automatic check_impulse(input string pfx);
        logic [6:0]  g_sys, g_par, g_done;
        logic [20:0] g_st;
        int          sym_bad;
        logic [6:0]  e_sys;
        e_sys   = 7'b1010001;
        g_sys   = '0; g_par = '0; g_done = '0; g_st = '0; sym_bad = 0;
        chk({pfx, "_count"}, 64'(q4.size()), 64'd7);
        for (int i = 0; i < q4.size() && i < 7; i++) begin
            g_done[i]       = q4[i][37];
            g_sys[i]        = q4[i][36];
            g_par[i]        = q4[i][35];
            g_st[3*i +: 3]  = q4[i][34:32];
            if ($signed(q4[i][31:16]) != (e_sys[i] ? -1024 : 1024)) sym_bad++;
            if ($signed(q4[i][15:0]) != -1024) sym_bad++;
        end
        chk({pfx, "_sys"}, 64'(g_sys), 64'(7'b1010001));
        chk({pfx, "_par"}, 64'(g_par), 64'(7'h7f));
        chk({pfx, "_state"}, 64'(g_st), 64'(21'b000_001_011_110_101_010_100));
        chk({pfx, "_done"}, 64'(g_done), 64'(7'b1000000));
        chk({pfx, "_sym_bad"}, 64'(sym_bad), 64'd0);
        if (q4.size() >= 7) chk({pfx, "_busy_at_done"}, 64'(q4[6][38]), 64'd0);
    endtask

    initial begin
        int bad, d0, exp_cnt;
        logic [2:0] s;
        logic p, u, b;
        logic [21:0] exp_q[$];

        // Reset: outputs must be 0 while rst is high
        #2;
        chk("rst_outputs", 64'({ov4, rdy4, busy4, done4, sys4, par4, st4, cnt4, ssym4, psym4}), 64'd0);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ov4 || rdy4 || busy4 || ov64 || rdy64 || busy64) bad++;
        end
        chk("idle_quiet", 64'(bad), 64'd0);

        // Impulse, FRAME_LEN=4; din_valid together with start must not be consumed
        q4.delete(); q4_cyc.delete();
        din = 1'b1; din_valid = 1'b1;
        pulse_start4();
        chk("ready_after_start", 64'({rdy4, busy4, cnt4}), 64'({2'b11, 8'd0}));
        chk("no_out_on_start", 64'(q4.size()), 64'd0);
        feed4(4'b0001, 0);
        check_impulse("impulse");
        chk("idle_sym_zero", 64'({ssym4, psym4, busy4}), 64'd0);
        chk("impulse_bitcnt", 64'(cnt4), 64'd4);

        // Backpressure: 2-cycle gap after the 2nd bit, with an ignored start
        q4.delete(); q4_cyc.delete();
        d0 = done4_cnt;
        pulse_start4();
        feed4(4'b0001, 2);
        check_impulse("bp");
        if (q4_cyc.size() >= 7) begin
            chk("bp_gap", 64'(q4_cyc[2] - q4_cyc[1]), 64'd3);
            chk("tail_b2b", 64'(q4_cyc[6] - q4_cyc[3]), 64'd3);
        end
        chk("bp_one_done", 64'(done4_cnt - d0), 64'd1);

        // Mid-frame reset after 3 bits
        pulse_start4();
        for (int i = 0; i < 3; i++) begin
            din = (i == 0); din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        d0 = done4_cnt;
        #2 rst = 1'b1;
        #1 chk("midrst_clear", 64'({ov4, busy4, rdy4, done4, sys4, par4, st4, cnt4, ssym4, psym4}), 64'd0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("midrst_no_done", 64'(done4_cnt - d0), 64'd0);
        q4.delete(); q4_cyc.delete();
        pulse_start4();
        feed4(4'b0001, 0);
        check_impulse("post_rst");

        // All-zero frame on FRAME_LEN=64
        q64.delete();
        start64 = 1'b1; tick(); start64 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            din = 1'b0; din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        repeat (8) tick();
        bad = 0;
        for (int i = 0; i < q64.size(); i++) begin
            if (q64[i][20:16] != 5'd0) bad++;
            if ($signed(q64[i][15:0]) != 1024) bad++;
            if (q64[i][21] != (i == 66)) bad++;
        end
        chk("zero_count", 64'(q64.size()), 64'd67);
        chk("zero_bad", 64'(bad), 64'd0);
        chk("zero_bitcnt", 64'(cnt64), 64'd64);

        // Random frames with random din_valid gaps against the reference model
        for (int fr = 0; fr < 20; fr++) begin
            q64.delete(); exp_q.delete();
            s = 3'b000;
            start64 = 1'b1; tick(); start64 = 1'b0;
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    din_valid = 1'b0;
                    din = 1'($urandom);
                    tick();
                end
                b = 1'($urandom);
                din = b; din_valid = 1'b1;
                ref_step(s, b, p, s);
                exp_q.push_back({1'b0, b, p, s, (b ? -16'sd1024 : 16'sd1024)});
                tick();
            end
            din_valid = 1'b0;
            for (int t = 0; t < 3; t++) begin
                u = s[1] ^ s[0];
                ref_step(s, u, p, s);
                exp_q.push_back({(t == 2), u, p, s, (u ? -16'sd1024 : 16'sd1024)});
            end
            repeat (8) tick();
            bad = 0;
            exp_cnt = (q64.size() < exp_q.size()) ? q64.size() : exp_q.size();
            for (int i = 0; i < exp_cnt; i++) if (q64[i] !== exp_q[i]) bad++;
            chk($sformatf("rand%0d_count", fr), 64'(q64.size()), 64'd67);
            chk($sformatf("rand%0d_bad", fr), 64'(bad), 64'd0);
            chk($sformatf("rand%0d_end_state", fr), 64'(st64), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rsc_encoder.md
# rsc_encoder

Frame-based 8-state recursive systematic convolutional encoder. It is the transmit-side counterpart of the MAP decoder chain: it generates the systematic and parity streams, plus BPSK-mapped signed 16-bit symbols, that the forward/backward recursions decode. Each frame ends with trellis termination (3 tail steps), so the decoder can assume that both the start state and the end state are 0.

## Interface

Parameters:
- FRAME_LEN, 64: information bits per frame; legal range 1..255.
- AMP, 16'sd1024: symbol magnitude; bit 0 maps to +AMP, bit 1 maps to -AMP.

Ports:
- clk  in  1  single clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame start request; honoured only in IDLE.
- din  in  1  information bit.
- din_valid  in  1  din is valid this cycle.
- din_ready  out  1  encoder accepts din this cycle; high only in DATA.
- sys_out  out  1  systematic bit (registered).
- par_out  out  1  parity bit (registered).
- sys_sym  out  16 signed  BPSK map of sys_out.
- par_sym  out  16 signed  BPSK map of par_out.
- out_valid  out  1  sys/par outputs are valid this cycle.
- trellis_state  out  3  current encoder state {s1,s2,s3}; s1 is the newest bit.
- bit_cnt  out  8  information bits accepted in the current frame.
- busy  out  1  high in DATA and TAIL.
- done  out  1  one-cycle pulse coincident with the last tail output.

## Operation

Reset and idle:
- All outputs are 0 in reset, and the FSM is in IDLE.
- sys_sym and par_sym are 0 in reset and in IDLE, and hold their last value between valid cycles.

FSM states:
- IDLE: start=1 moves the FSM to DATA and clears bit_cnt and trellis_state.
- DATA: each accepted bit increments bit_cnt. When bit FRAME_LEN is accepted, the FSM moves to TAIL.
- TAIL: the FSM takes exactly 3 steps, then returns to IDLE.

Code (generators 13/15 octal):
- Feedback: f = u ^ s2 ^ s3.
- Parity: p = f ^ s1 ^ s3.
- Next state: {f, s1, s2}.
- sys_out = u.

Data and tail steps:
- A DATA step occurs when din_valid & din_ready; in that step u = din.
- A TAIL step occurs every cycle while in TAIL, regardless of din_valid, with u = s2 ^ s3. This forces f=0, so the state reaches 000 after 3 steps.
- Each frame therefore emits FRAME_LEN+3 valid output pairs. The tail systematic bits are emitted on sys_out.

Boundary conditions:
- start while busy is ignored.
- din_valid in IDLE or TAIL is ignored; din_ready is 0 there.
- start and din_valid in the same IDLE cycle: din is not consumed. The first accepted bit arrives at the earliest one cycle later.
- A din_valid gap in DATA gives out_valid=0 that cycle, and trellis_state and bit_cnt hold.
- rst asserted mid-frame aborts the frame immediately: all outputs go to 0 and the FSM to IDLE, with no done pulse.
- FRAME_LEN=1 gives 1 data step followed by 3 tail steps.

## Timing

- din_ready is decoded combinationally from the registered FSM state.
- Latency is 1 cycle: a step taken at edge k shows its results after edge k.
  - Updated at edge k: sys_out, par_out, sys_sym, par_sym, trellis_state, bit_cnt.
  - out_valid=1 for the cycle following edge k.
- Tail steps run back to back: the 3 tail outputs occupy the 3 cycles immediately after the last data output.
- done=1 only during the cycle that carries the third tail output. In that same cycle busy=0, the FSM is in IDLE, and trellis_state=000.
- A new start is accepted in that same done cycle. Minimum frame period is FRAME_LEN+4 cycles with continuous din_valid.
- out_valid never exceeds 1 pulse per step, and there are no bubbles inside TAIL.

## Test plan

- Reset: assert rst mid-cycle and check all outputs are 0 asynchronously.
  - Release rst, hold start=0 for 10 cycles: out_valid, din_ready and busy stay 0.
- Impulse, FRAME_LEN=4, din = 1,0,0,0 with continuous valid:
  - sys = 1,0,0,0,1,0,1.
  - par = 1,1,1,1,1,1,1.
  - trellis_state after each step = 100,010,101,110,011,001,000.
  - done on the 7th output; sys_sym = -1024,+1024,+1024,+1024,-1024,+1024,-1024.
- All-zero frame, FRAME_LEN=64: 67 outputs, all sys=0 and par=0, symbols +1024, trellis_state 000 throughout; bit_cnt reaches 64.
- Backpressure, impulse vector with din_valid deasserted for 2 cycles after the 2nd bit:
  - out_valid has a 2-cycle gap there.
  - Output sequence is identical to the impulse case.
  - A start pulse during busy is ignored.
- Reset mid-frame after 3 bits: outputs clear and no done pulse is seen.
  - A following frame with din = 1,0,0,0 reproduces the impulse result exactly.
- Random: 20 frames of FRAME_LEN=64 with random din and random din_valid gaps, compared against the reference model.
  - Every frame ends with trellis_state=000 and exactly 67 valid outputs.
